// File: rtl/stage2_wb_pkg.sv
// stage2_wb_pkg: stage tags, bank map and FSM states shared by the stage-2 result writer
package stage2_wb_pkg;

    typedef enum logic [2:0] {
        S_SCALE0, S_SCALE1, S_SCALE2, S_SCALE3, S_STAGE4, S_STAGE5, S_CID, S_FINISH
    } stage_e;

    localparam int BANK_S03   = 0;
    localparam int BANK_S4    = 1;
    localparam int BANK_S5    = 2;
    localparam int BANK_CID   = 3;
    localparam int BANK_DNORM = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_e;

    // Port A bank for a stage; stage 6 additionally writes bank 4 on port B
    function automatic logic [1:0] bank_of(stage_e s);
        return s == S_STAGE4 ? 2'(BANK_S4) :
               s == S_STAGE5 ? 2'(BANK_S5) :
               s == S_CID    ? 2'(BANK_CID) : 2'(BANK_S03);
    endfunction

endpackage

// File: rtl/stage2_result_writer_if.sv
// stage2_result_writer_if: stage-2 pipe beat inputs, stall, and SRAM write ports A/B
interface stage2_result_writer_if #(
    parameter int WIDTH         = 16,
    parameter int PARALLEL_SIZE = 2,
    parameter int ADDR_W        = 12
);
    localparam int DW = WIDTH * PARALLEL_SIZE;

    logic              valid_i;
    logic [2:0]        stage_i;
    logic              finished_i;
    logic [DW-1:0]     operand1_i;
    logic [DW-1:0]     operand2_i;
    logic              stall_o;
    logic              sram_ready_i;
    logic              wa_en_o;
    logic [1:0]        wa_bank_o;
    logic [ADDR_W-1:0] wa_addr_o;
    logic [DW-1:0]     wa_data_o;
    logic              wb_en_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DW-1:0]     wb_data_o;

    modport slave (
        input  valid_i, stage_i, finished_i, operand1_i, operand2_i, sram_ready_i,
        output stall_o, wa_en_o, wa_bank_o, wa_addr_o, wa_data_o, wb_en_o, wb_addr_o, wb_data_o
    );

    modport master (
        output valid_i, stage_i, finished_i, operand1_i, operand2_i, sram_ready_i,
        input  stall_o, wa_en_o, wa_bank_o, wa_addr_o, wa_data_o, wb_en_o, wb_addr_o, wb_data_o
    );

endinterface

// File: rtl/stage2_wb_fifo.sv
// stage2_wb_fifo: synchronous FIFO with occupancy count and synchronous clear; DEPTH power of 2
module stage2_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   CLK_i,
    input  logic                   RST_i,
    input  logic                   clr,
    input  logic                   wr,
    input  logic [W-1:0]           din,
    input  logic                   rd,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          we, re;

    assign empty = count == '0;
    assign we    = wr && count != CW'(DEPTH);
    assign re    = rd && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(we);
            rp    <= rp + AW'(re);
            count <= count + CW'(we) - CW'(re);
        end
    end

    always_ff @(posedge CLK_i)
        if (we) mem[wp] <= din;

endmodule

// File: rtl/stage2_result_writer.sv
// stage2_result_writer: buffers stage-2 result beats and writes them into SRAM banks 0..4.
// Define STAGE2_WB_OVF_CHECK_EN to add the sticky ovf_o drop flag and a drop assertion.
module stage2_result_writer
    import stage2_wb_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int PARALLEL_SIZE = 2,
    parameter int ADDR_W        = 12,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    CLK_i,
    input  logic                    RST_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    stage2_result_writer_if.slave   bus
`ifdef STAGE2_WB_OVF_CHECK_EN
    ,
    output logic                    ovf_o
`endif
);
    localparam int DW = WIDTH * PARALLEL_SIZE;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        stage_e        stage;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } beat_t;

    fsm_e              state;
    beat_t             din, head;
    logic [CW-1:0]     count;
    logic              empty, clr, push, pop;
    logic [1:0]        hb;
    logic [2:0]        hi;
    logic [ADDR_W-1:0] ptr [5];

    assign clr         = state == IDLE && start_i;
    assign push        = state == RUN && bus.valid_i && stage_e'(bus.stage_i) != S_FINISH;
    assign pop         = !empty && bus.sram_ready_i;
    assign din         = '{stage: stage_e'(bus.stage_i), op1: bus.operand1_i, op2: bus.operand2_i};
    assign hb          = bank_of(head.stage);
    assign hi          = {1'b0, hb};
    // Keeps one slot free for the beat the producer issues during the stall cycle
    assign bus.stall_o = (state == RUN || state == DRAIN) && count >= CW'(FIFO_DEPTH - 1);
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE;

    stage2_wb_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .clr   (clr),
        .wr    (push),
        .din   (din),
        .rd    (pop),
        .dout  (head),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i)
            state <= IDLE;
        else
            state <= state == IDLE  ? (start_i ? RUN : IDLE) :
                     state == RUN   ? (bus.finished_i ? DRAIN : RUN) :
                     state == DRAIN ? (empty && !bus.wa_en_o ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            bus.wa_en_o   <= 1'b0;
            bus.wa_bank_o <= '0;
            bus.wa_addr_o <= '0;
            bus.wa_data_o <= '0;
            bus.wb_en_o   <= 1'b0;
            bus.wb_addr_o <= '0;
            bus.wb_data_o <= '0;
            ptr           <= '{default: '0};
        end else begin
            bus.wa_en_o <= pop;
            bus.wb_en_o <= pop && head.stage == S_CID;
            if (clr) begin
                ptr <= '{default: '0};
            end else if (pop) begin
                bus.wa_bank_o <= hb;
                bus.wa_addr_o <= ptr[hi];
                bus.wa_data_o <= head.op1;
                ptr[hi]       <= ptr[hi] + ADDR_W'(1);
                if (head.stage == S_CID) begin
                    bus.wb_addr_o          <= ptr[3'(BANK_DNORM)];
                    bus.wb_data_o          <= head.op2;
                    ptr[3'(BANK_DNORM)]    <= ptr[3'(BANK_DNORM)] + ADDR_W'(1);
                end
            end
        end
    end

`ifdef STAGE2_WB_OVF_CHECK_EN
    logic drop;
    assign drop = push && count == CW'(FIFO_DEPTH);

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i)
            ovf_o <= 1'b0;
        else if (clr)
            ovf_o <= 1'b0;
        else if (drop)
            ovf_o <= 1'b1;
    end

    a_no_drop: assert property (@(posedge CLK_i) disable iff (RST_i) !drop);
`endif

endmodule

// File: tb/tb_stage2_result_writer.sv
// tb_stage2_result_writer: randomized bench checking SRAM writes against a queue-based model
module tb_stage2_result_writer;
    localparam int WIDTH = 16, PS = 2, AW = 2, DEPTH = 4, DW = WIDTH * PS;

    typedef struct packed {
        logic [2:0]    bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } wr_t;

    typedef struct {
        int            stage;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } beat_t;

    logic CLK_i = 1'b0, RST_i = 1'b1, start_i = 1'b0, busy_o, done_o;
`ifdef STAGE2_WB_OVF_CHECK_EN
    logic ovf_o;
`endif

    int    errors = 0, checks = 0, edges = 0, done_cnt = 0, mmode = 0;
    bit    mlast_pop = 0, mdrop = 0;
    int    mptr [5];
    beat_t mq [$];
    wr_t   exp_q [$], act_q [$];

    stage2_result_writer_if #(.WIDTH(WIDTH), .PARALLEL_SIZE(PS), .ADDR_W(AW)) bus ();

    stage2_result_writer #(.WIDTH(WIDTH), .PARALLEL_SIZE(PS), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_i   (CLK_i),
        .RST_i   (RST_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
`ifdef STAGE2_WB_OVF_CHECK_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 CLK_i = ~CLK_i;

    always @(negedge CLK_i) begin
        if (bus.wa_en_o) act_q.push_back(wr_t'({1'b0, bus.wa_bank_o, bus.wa_addr_o, bus.wa_data_o, 32'(edges)}));
        if (bus.wb_en_o) act_q.push_back(wr_t'({3'd4, bus.wb_addr_o, bus.wb_data_o, 32'(edges)}));
        if (done_o) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Drives one cycle and advances the model: FIFO of accepted beats, per-bank pointers
    task automatic tick(input bit v, input int st, input logic [DW-1:0] o1, input logic [DW-1:0] o2,
                        input bit rdy, input bit fin, input bit strt);
        bit    push, pop, acc;
        beat_t b;
        int    bk;
        bus.valid_i = v; bus.stage_i = 3'(st); bus.operand1_i = o1; bus.operand2_i = o2;
        bus.sram_ready_i = rdy; bus.finished_i = fin; start_i = strt;
        @(posedge CLK_i);
        edges++;
        push = mmode == 1 && v && st != 7;
        pop  = mq.size() > 0 && rdy;
        acc  = push && mq.size() < DEPTH;
        if (push && !acc) mdrop = 1;
        if (mmode == 0 && strt) begin
            mmode = 1; mq.delete(); mptr = '{default: 0}; mdrop = 0;
        end else if (mmode == 1 && fin) mmode = 2;
        else if (mmode == 2 && mq.size() == 0 && !mlast_pop) mmode = 3;
        else if (mmode == 3) mmode = 0;
        if (pop) begin
            b  = mq.pop_front();
            bk = b.stage <= 3 ? 0 : b.stage - 3;
            exp_q.push_back(wr_t'({3'(bk), AW'(mptr[bk]), b.op1, 32'(edges)}));
            mptr[bk] = (mptr[bk] + 1) % (1 << AW);
            if (b.stage == 6) begin
                exp_q.push_back(wr_t'({3'd4, AW'(mptr[4]), b.op2, 32'(edges)}));
                mptr[4] = (mptr[4] + 1) % (1 << AW);
            end
        end
        if (acc) mq.push_back('{st, o1, o2});
        mlast_pop = pop;
        @(negedge CLK_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) tick(0, 0, '0, '0, rdy, 0, 0);
    endtask

    task automatic start_run;
        tick(0, 0, '0, '0, 1, 0, 1);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input bit rdy, output bit seen);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done_o) seen = 1;
            else tick(0, 0, '0, '0, rdy, 0, 0);
        end
        tick(0, 0, '0, '0, rdy, 0, 0);
    endtask

    task automatic finish_run(input bit rdy, output bit seen);
        tick(0, 0, '0, '0, rdy, 1, 0);
        wait_done(rdy, seen);
    endtask

    task automatic test_reset;
        RST_i = 1;
        idle(2, 0);
        checks++;
        if ({busy_o, done_o, bus.stall_o, bus.wa_en_o, bus.wb_en_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy_o, done_o, bus.stall_o, bus.wa_en_o, bus.wb_en_o});
        end
        checks++;
        if ({bus.wa_bank_o, bus.wa_addr_o, bus.wa_data_o, bus.wb_addr_o, bus.wb_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {bus.wa_bank_o, bus.wa_addr_o, bus.wa_data_o, bus.wb_addr_o, bus.wb_data_o});
        end
        RST_i = 0;
        idle(1, 0);
    endtask

    task automatic test_stage4;
        logic [DW-1:0] o1 [3];
        int            p [3];
        bit            seen;
        o1 = '{32'h3C00_4000, 32'h4000_4200, 32'h4200_4400};
        start_run();
        for (int i = 0; i < 3; i++) begin
            tick(1, 4, o1[i], DW'($urandom()), 1, 0, 0);
            p[i] = edges;
        end
        idle(3, 1);
        checks++;
        if (act_q.size() != 3) begin
            errors++;
            $display("FAIL s4_count: got %0d writes want 3", act_q.size());
        end
        for (int i = 0; i < 3 && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== wr_t'({3'd1, AW'(i), o1[i], 32'(p[i] + 1)})) begin
                errors++;
                $display("FAIL s4_write%0d: got %h want %h", i, act_q[i], wr_t'({3'd1, AW'(i), o1[i], 32'(p[i] + 1)}));
            end
        end
        finish_run(1, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL s4_done: got no done_o want pulse"); end
    endtask

    task automatic test_stage6;
        logic [DW-1:0] o1, o2;
        int            p;
        bit            seen;
        o1 = {16'h0005, 16'h0007};
        o2 = {16'h3C00, 16'h3800};
        start_run();
        tick(1, 6, o1, o2, 1, 0, 0);
        p = edges;
        idle(3, 1);
        checks++;
        if (act_q.size() != 2) begin
            errors++;
            $display("FAIL s6_count: got %0d writes want 2", act_q.size());
        end else begin
            checks++;
            if (act_q[0] !== wr_t'({3'd3, AW'(0), o1, 32'(p + 1)})) begin
                errors++;
                $display("FAIL s6_porta: got %h want %h", act_q[0], wr_t'({3'd3, AW'(0), o1, 32'(p + 1)}));
            end
            checks++;
            if (act_q[1] !== wr_t'({3'd4, AW'(0), o2, 32'(p + 1)})) begin
                errors++;
                $display("FAIL s6_portb: got %h want %h", act_q[1], wr_t'({3'd4, AW'(0), o2, 32'(p + 1)}));
            end
        end
        finish_run(1, seen);
    endtask

    task automatic test_backpressure;
        bit seen;
        start_run();
        for (int i = 0; i < 5; i++) begin
            tick(1, int'($urandom_range(0, 6)), DW'($urandom()), DW'($urandom()), 0, 0, 0);
            checks++;
            if (bus.stall_o !== (i >= 2)) begin
                errors++;
                $display("FAIL bp_stall%0d: got %b want %b", i, bus.stall_o, i >= 2);
            end
        end
`ifdef STAGE2_WB_OVF_CHECK_EN
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", ovf_o); end
`endif
        idle(7, 1);
        checks++;
        if (act_q.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d writes want 4", act_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL bp_release: got stall %b want 0", bus.stall_o); end
        finish_run(1, seen);
    endtask

    task automatic test_drain;
        bit seen;
        int base, n;
        start_run();
        base = done_cnt;
        for (int i = 0; i < 2; i++) tick(1, int'($urandom_range(0, 6)), DW'($urandom()), DW'($urandom()), 0, 0, 0);
        tick(1, 5, DW'($urandom()), DW'($urandom()), 1, 1, 0);
        wait_done(1, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL drain_done: got no done_o want pulse"); end
        checks++;
        if (act_q.size() != 3) begin
            errors++;
            $display("FAIL drain_count: got %0d writes want 3", act_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL drain_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - base != 1) begin errors++; $display("FAIL drain_pulses: got %0d want 1", done_cnt - base); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy_o); end
        n = act_q.size();
        for (int i = 0; i < 4; i++) tick(1, 0, DW'($urandom()), '0, 1, 0, 0);
        checks++;
        if (act_q.size() != n) begin errors++; $display("FAIL idle_writes: got %0d writes want %0d", act_q.size(), n); end
    endtask

    task automatic test_wrap_reset;
        int exp_addr [5];
        int base, n;
        exp_addr = '{0, 1, 2, 3, 0};
        start_run();
        for (int i = 0; i < 5; i++) tick(1, 5, DW'($urandom()), '0, 1, 0, 0);
        idle(3, 1);
        checks++;
        if (act_q.size() != 5) begin errors++; $display("FAIL wrap_count: got %0d writes want 5", act_q.size()); end
        for (int i = 0; i < 5 && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i].bank !== 3'd2 || act_q[i].addr !== AW'(exp_addr[i])) begin
                errors++;
                $display("FAIL wrap_addr%0d: got bank %0d addr %0d want bank 2 addr %0d", i, act_q[i].bank, act_q[i].addr, exp_addr[i]);
            end
        end
        for (int i = 0; i < 2; i++) tick(1, 0, DW'($urandom()), '0, 0, 0, 0);
        base = done_cnt;
        n = act_q.size();
        RST_i = 1;
        #1;
        checks++;
        if ({busy_o, done_o, bus.stall_o, bus.wa_en_o, bus.wb_en_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async: got %b want 00000", {busy_o, done_o, bus.stall_o, bus.wa_en_o, bus.wb_en_o});
        end
        mmode = 0; mq.delete(); mlast_pop = 0; mptr = '{default: 0}; mdrop = 0;
        idle(2, 1);
        RST_i = 0;
        idle(4, 1);
        checks++;
        if (act_q.size() != n || done_cnt != base) begin
            errors++;
            $display("FAIL rst_quiet: got %0d writes %0d dones want %0d writes %0d dones", act_q.size(), done_cnt, n, base);
        end
    endtask

    task automatic test_random;
        bit seen;
        int base;
        start_run();
        base = done_cnt;
        for (int c = 0; c < 300; c++) begin
            tick($urandom_range(0, 2) != 0, int'($urandom_range(0, 7)), DW'($urandom()), DW'($urandom()),
                 $urandom_range(0, 3) != 0, 0, 0);
            checks++;
            if (bus.stall_o !== ((mmode == 1 || mmode == 2) && mq.size() >= DEPTH - 1)) begin
                errors++;
                $display("FAIL rnd_stall@%0d: got %b want %b", edges, bus.stall_o, (mmode == 1 || mmode == 2) && mq.size() >= DEPTH - 1);
            end
        end
        finish_run(1, seen);
        checks++;
        if (!seen || done_cnt - base != 1) begin
            errors++;
            $display("FAIL rnd_done: got seen=%b pulses=%0d want seen=1 pulses=1", seen, done_cnt - base);
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count: got %0d writes want %0d", act_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_write%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stage4();
        test_stage6();
        test_backpressure();
        test_drain();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
